// File: rtl/pwr_efuse_pkg.sv
// ----------------------------------------------------------------------------
// pwr_efuse_pkg
//  Shared definitions for the eFuse shadow-load controller and the register
//  bank top. Holds the loader state encoding, the default shadow-register
//  count and data width, and the eFuse word index type.
// ----------------------------------------------------------------------------
package pwr_efuse_pkg;

   localparam int unsigned EFUSE_REG_NUM = 8;
   localparam int unsigned EFUSE_DW      = 8;
   localparam int unsigned EFUSE_IDX_W   = $clog2(EFUSE_REG_NUM);

   // eFuse word index as seen by the register bank (word k shadows register k)
   typedef logic [EFUSE_IDX_W-1:0] efuse_idx_t;

   // Loader sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } efuse_ld_st_e;

endpackage : pwr_efuse_pkg

// File: rtl/efuse_load_ctrl.sv
// ----------------------------------------------------------------------------
// efuse_load_ctrl
//  Sequences the eFuse-to-register shadow load. After reset (AUTO_LOAD=1) or
//  on i_load_start, reads REG_NUM eFuse words over a req/ack handshake and
//  pulses the matching register's logic-write enable for one cycle per word.
//  A word whose ack does not arrive within TIMEOUT_CYC request cycles is
//  skipped and counted as an error. All outputs are registered.
//
// Ports
//  i_clk, i_rst_n        clock, async active-low reset
//  i_load_start          single-cycle reload request (ignored while busy)
//  o_efuse_rd_req        eFuse read request, held until ack or timeout
//  o_efuse_addr          eFuse word index
//  i_efuse_ack           single-cycle read completion, data valid same cycle
//  i_efuse_rdata         eFuse read data
//  o_efuse_ctrl_reg_en   logic-write enable to the register bank while loading
//  o_lgc_wen             per-register write enable, slice k loads register k
//  o_lgc_wdata           write data broadcast to all shadowed registers
//  o_busy                load sequence in progress
//  o_done                sticky: last sequence finished
//  o_err                 sticky: at least one word timed out in last sequence
//  o_err_cnt             number of timed-out words in last sequence
// ----------------------------------------------------------------------------
module efuse_load_ctrl
   import pwr_efuse_pkg::*;
#(
   parameter  int unsigned DW          = EFUSE_DW,
   parameter  int unsigned REG_NUM     = EFUSE_REG_NUM,
   parameter  bit          AUTO_LOAD   = 1'b1,
   parameter  int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned CW          = $clog2(REG_NUM),
   localparam int unsigned ECW         = CW + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load_start,
   output logic                  o_efuse_rd_req,
   output logic [CW-1:0]         o_efuse_addr,
   input  logic                  i_efuse_ack,
   input  logic [DW-1:0]         i_efuse_rdata,
   output logic                  o_efuse_ctrl_reg_en,
   output logic [REG_NUM*DW-1:0] o_lgc_wen,
   output logic [DW-1:0]         o_lgc_wdata,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [ECW-1:0]        o_err_cnt
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
   localparam int unsigned WW = REG_NUM * DW;

   efuse_ld_st_e     r_state;
   logic [CW-1:0]    r_idx;
   logic [TW-1:0]    r_cnt;
   logic             r_rd_req;
   logic             r_reg_en;
   logic [WW-1:0]    r_lgc_wen;
   logic [DW-1:0]    r_wdata;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [ECW-1:0]   r_err_cnt;

   efuse_ld_st_e     w_state_nxt;
   logic [CW-1:0]    w_idx_nxt;
   logic [TW-1:0]    w_cnt_nxt;
   logic             w_rd_req_nxt;
   logic             w_active_nxt;
   logic [WW-1:0]    w_lgc_wen_nxt;
   logic [DW-1:0]    w_wdata_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;
   logic [ECW-1:0]   w_err_cnt_nxt;
   logic             w_last;
   logic             w_start;

   assign w_last = (r_idx == CW'(REG_NUM - 1));

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_cnt_nxt     = r_cnt;
      w_rd_req_nxt  = 1'b0;
      w_lgc_wen_nxt = '0;
      w_wdata_nxt   = r_wdata;
      w_done_nxt    = r_done;
      w_err_nxt     = r_err;
      w_err_cnt_nxt = r_err_cnt;
      w_start       = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (AUTO_LOAD || i_load_start) w_start = 1'b1;
         end

         REQ: begin
            if (!r_rd_req) begin
               // One-cycle gap after a timeout; counter already cleared
               w_rd_req_nxt = 1'b1;
            end else if (i_efuse_ack) begin
               // Ack wins over a timeout expiring in the same cycle
               w_state_nxt = WR;
               w_wdata_nxt = i_efuse_rdata;
               w_cnt_nxt   = '0;
               for (int unsigned k = 0; k < REG_NUM; k++) begin
                  if (r_idx == CW'(k)) w_lgc_wen_nxt[k*DW +: DW] = {DW{1'b1}};
               end
            end else if (r_cnt == TW'(TIMEOUT_CYC - 1)) begin
               // Skip this word without writing its register
               w_cnt_nxt = '0;
               w_err_nxt = 1'b1;
               if (r_err_cnt != ECW'(REG_NUM)) w_err_cnt_nxt = r_err_cnt + ECW'(1);
               if (w_last) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + CW'(1);
               end
            end else begin
               w_rd_req_nxt = 1'b1;
               w_cnt_nxt    = r_cnt + TW'(1);
            end
         end

         WR: begin
            if (w_last) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt  = REQ;
               w_idx_nxt    = r_idx + CW'(1);
               w_cnt_nxt    = '0;
               w_rd_req_nxt = 1'b1;
            end
         end

         DONE: begin
            if (i_load_start) w_start = 1'b1;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // New sequence always begins at word 0 with cleared status
      if (w_start) begin
         w_state_nxt   = REQ;
         w_idx_nxt     = '0;
         w_cnt_nxt     = '0;
         w_rd_req_nxt  = 1'b1;
         w_done_nxt    = 1'b0;
         w_err_nxt     = 1'b0;
         w_err_cnt_nxt = '0;
      end

      w_active_nxt = (w_state_nxt == REQ) || (w_state_nxt == WR);
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_rd_req  <= 1'b0;
         r_reg_en  <= 1'b0;
         r_lgc_wen <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rd_req  <= w_rd_req_nxt;
         r_reg_en  <= w_active_nxt;
         r_lgc_wen <= w_lgc_wen_nxt;
         r_wdata   <= w_wdata_nxt;
         r_busy    <= w_active_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   assign o_efuse_rd_req      = r_rd_req;
   assign o_efuse_addr        = r_idx;
   assign o_efuse_ctrl_reg_en = r_reg_en;
   assign o_lgc_wen           = r_lgc_wen;
   assign o_lgc_wdata         = r_wdata;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_err               = r_err;
   assign o_err_cnt           = r_err_cnt;

endmodule : efuse_load_ctrl

// File: tb/tb_efuse_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_efuse_load_ctrl
//  Directed bench for efuse_load_ctrl. Two instances share clock and reset:
//  u_dut_auto (AUTO_LOAD=1) and u_dut_man (AUTO_LOAD=0); sel steers the
//  handshake inputs to one of them and muxes its outputs onto the observed
//  signals. A small register-bank model applies lgc writes and SPI writes.
// ----------------------------------------------------------------------------
module tb_efuse_load_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned RN = 8;
   localparam int unsigned CW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, ack, sel;
   logic [DW-1:0] rdata;
   logic          spi_wen;
   logic [CW-1:0] spi_idx;
   logic [DW-1:0] spi_data;
   logic          bank_init;

   // per-instance outputs
   logic          a_req, a_en, a_busy, a_done, a_err;
   logic [CW-1:0] a_addr;
   logic [63:0]   a_wen;
   logic [DW-1:0] a_wdata;
   logic [CW:0]   a_ecnt;
   logic          b_req, b_en, b_busy, b_done, b_err;
   logic [CW-1:0] b_addr;
   logic [63:0]   b_wen;
   logic [DW-1:0] b_wdata;
   logic [CW:0]   b_ecnt;

   // observed (selected) outputs
   logic          req, en, busy, done, err;
   logic [CW-1:0] addr;
   logic [63:0]   wen;
   logic [DW-1:0] wdata;
   logic [CW:0]   ecnt;

   assign req   = sel ? b_req   : a_req;
   assign en    = sel ? b_en    : a_en;
   assign busy  = sel ? b_busy  : a_busy;
   assign done  = sel ? b_done  : a_done;
   assign err   = sel ? b_err   : a_err;
   assign addr  = sel ? b_addr  : a_addr;
   assign wen   = sel ? b_wen   : a_wen;
   assign wdata = sel ? b_wdata : a_wdata;
   assign ecnt  = sel ? b_ecnt  : a_ecnt;

   efuse_load_ctrl #(.DW(DW), .REG_NUM(RN), .AUTO_LOAD(1'b1), .TIMEOUT_CYC(64)) u_dut_auto (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_load_start        (start & ~sel),
      .o_efuse_rd_req      (a_req),
      .o_efuse_addr        (a_addr),
      .i_efuse_ack         (ack & ~sel),
      .i_efuse_rdata       (rdata),
      .o_efuse_ctrl_reg_en (a_en),
      .o_lgc_wen           (a_wen),
      .o_lgc_wdata         (a_wdata),
      .o_busy              (a_busy),
      .o_done              (a_done),
      .o_err               (a_err),
      .o_err_cnt           (a_ecnt)
   );

   efuse_load_ctrl #(.DW(DW), .REG_NUM(RN), .AUTO_LOAD(1'b0), .TIMEOUT_CYC(64)) u_dut_man (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_load_start        (start & sel),
      .o_efuse_rd_req      (b_req),
      .o_efuse_addr        (b_addr),
      .i_efuse_ack         (ack & sel),
      .i_efuse_rdata       (rdata),
      .o_efuse_ctrl_reg_en (b_en),
      .o_lgc_wen           (b_wen),
      .o_lgc_wdata         (b_wdata),
      .o_busy              (b_busy),
      .o_done              (b_done),
      .o_err               (b_err),
      .o_err_cnt           (b_ecnt)
   );

   // Register bank model: SPI write to the same register wins over lgc write
   logic [DW-1:0] bank [RN];
   int            pulses = 0;
   always @(posedge clk) begin
      for (int k = 0; k < RN; k++) begin
         if (bank_init)                                bank[k] <= 8'hDD;
         else if (spi_wen && spi_idx == CW'(k))        bank[k] <= spi_data;
         else if (wen[k*DW +: DW] == 8'hFF && en)      bank[k] <= wdata;
      end
      if (wen != 64'd0) pulses <= pulses + 1;
   end

   int            n_chk = 0;
   int            n_err = 0;
   int            ack_dly [RN];
   logic [DW-1:0] rd_val  [RN];
   int            skip_k, spi_k, abort_k, bstart_k;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_data(input logic [DW-1:0] base, input int dly);
      for (int k = 0; k < RN; k++) begin
         rd_val[k]  = base + DW'(k);
         ack_dly[k] = dly;
      end
   endtask

   task automatic clear_bank();
      bank_init = 1'b1;
      @(negedge clk);
      bank_init = 1'b0;
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({req, en, busy, done, err, addr, ecnt, wdata}), 64'd0);
      chk({tag, "_wen"}, wen, 64'd0);
   endtask

   task automatic chk_bank(input string tag);
      for (int k = 0; k < RN; k++) begin
         logic [DW-1:0] exp;
         exp = (k == skip_k) ? 8'hDD : rd_val[k];
         chk($sformatf("%s_bank%0d", tag, k), 64'(bank[k]), 64'(exp));
      end
   endtask

   // Reload request; checks the first request cycle and cleared status
   task automatic pulse_start(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start"}, 64'({req, busy, en, done, err, ecnt, addr}), 64'({3'b111, 2'b00, 4'd0, 3'd0}));
   endtask

   // Serves one sequence, entered at the negedge where word 0 request is high
   task automatic run_seq(input string tag);
      for (int k = 0; k < RN; k++) begin
         chk($sformatf("%s_req%0d", tag, k), 64'({req, addr}), 64'({1'b1, 3'(k)}));
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            chk_outs_zero({tag, "_abort"});
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (k == skip_k) begin
            int cnt;
            cnt = 1;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (!req) break;
               cnt++;
            end
            chk($sformatf("%s_tmo_len%0d", tag, k), 64'(cnt), 64'd64);
            chk($sformatf("%s_tmo_err%0d", tag, k), 64'({err, wen != 64'd0}), 64'({1'b1, 1'b0}));
            if (k < RN - 1) @(negedge clk);
            else chk({tag, "_done"}, 64'({done, busy, en}), 64'(3'b100));
         end else begin
            bit dropped;
            dropped = 1'b0;
            if (k == bstart_k) start = 1'b1;
            for (int i = 0; i < ack_dly[k]; i++) begin
               @(negedge clk);
               start = 1'b0;
               if (!req) dropped = 1'b1;
            end
            chk($sformatf("%s_held%0d", tag, k), 64'(dropped), 64'd0);
            ack   = 1'b1;
            rdata = rd_val[k];
            @(negedge clk);
            ack   = 1'b0;
            start = 1'b0;
            chk($sformatf("%s_wen%0d", tag, k), wen, 64'(8'hFF) << (8 * k));
            chk($sformatf("%s_wd%0d", tag, k), 64'({req, wdata}), 64'({1'b0, rd_val[k]}));
            if (k == spi_k) begin
               spi_wen  = 1'b1;
               spi_idx  = CW'(k);
               spi_data = 8'h11;
            end
            @(negedge clk);
            spi_wen = 1'b0;
            if (k == RN - 1)
               chk({tag, "_done"}, 64'({done, busy, en, wen != 64'd0, wdata}), 64'({4'b1000, rd_val[k]}));
         end
      end
   endtask

   initial begin
      int  p0;
      bit  seen;
      rst_n = 1'b0; start = 1'b0; ack = 1'b0; rdata = '0; sel = 1'b0;
      spi_wen = 1'b0; spi_idx = '0; spi_data = '0; bank_init = 1'b1;
      skip_k = -1; spi_k = -1; abort_k = -1; bstart_k = -1;
      repeat (3) @(negedge clk);
      chk_outs_zero("rst_auto");
      sel = 1'b1; #1;
      chk_outs_zero("rst_man");
      sel = 1'b0;
      bank_init = 1'b0;

      // Auto load after reset release, ack 3 cycles after each request
      set_data(8'hA0, 3);
      p0 = pulses;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_first", 64'({req, busy, en, addr}), 64'({3'b111, 3'd0}));
      run_seq("t1");
      chk_bank("t1");
      chk("t1_status", 64'({err, ecnt}), 64'd0);
      chk("t1_pulses", 64'(pulses - p0), 64'd8);

      // Word 3 never acked
      clear_bank();
      set_data(8'hB0, 2);
      skip_k = 3;
      pulse_start("t2");
      run_seq("t2");
      chk_bank("t2");
      chk("t2_status", 64'({done, err, ecnt}), 64'({2'b11, 4'd1}));
      skip_k = -1;

      // Ack in the cycle the timeout expires on word 0
      clear_bank();
      set_data(8'hC0, 1);
      ack_dly[0] = 63;
      rd_val[0]  = 8'h5A;
      pulse_start("t4");
      run_seq("t4");
      chk_bank("t4");
      chk("t4_status", 64'({done, err, ecnt}), 64'({2'b10, 4'd0}));

      // SPI write wins in the WR cycle, then a reload restores the eFuse value
      set_data(8'hD0, 2);
      spi_k = 2;
      pulse_start("t6a");
      run_seq("t6a");
      chk("t6a_spi", 64'(bank[2]), 64'h11);
      spi_k = -1;
      set_data(8'hE0, 2);
      pulse_start("t6b");
      run_seq("t6b");
      chk_bank("t6b");

      // Reset while word 4 is requested, auto reload from word 0
      set_data(8'hF0, 2);
      abort_k = 4;
      p0 = pulses;
      pulse_start("t5");
      run_seq("t5");
      chk("t5_pulses", 64'(pulses - p0), 64'd4);
      abort_k = -1;
      @(negedge clk);
      run_seq("t5r");
      chk_bank("t5r");

      // Manual-start instance: idle until start, start while busy ignored
      sel = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (req || busy) seen = 1'b1;
      end
      chk("t3_idle", 64'(seen), 64'd0);
      clear_bank();
      set_data(8'h30, 2);
      bstart_k = 2;
      p0 = pulses;
      pulse_start("t3");
      run_seq("t3");
      bstart_k = -1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (req || busy) seen = 1'b1;
      end
      chk("t3_no_rerun", 64'(seen), 64'd0);
      chk("t3_pulses", 64'(pulses - p0), 64'd8);
      chk_bank("t3");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_efuse_load_ctrl
